// File: rtl/sys_cmd_ctrl_if.sv
// Bus bundle between the command sequencer and its RX / register file / ALU / TX neighbours.
// Latency: none, wires only.
// Backpressure: FIFO_FULL from the TX FIFO is the only stall signal carried here.
interface sys_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int ADDR       = 4
);
  // RX side
  logic [DATA_WIDTH-1:0] RX_P_DATA;
  logic                  RX_D_VLD;
  // register file side
  logic                  WrEn;
  logic                  RdEn;
  logic [ADDR-1:0]       Address;
  logic [DATA_WIDTH-1:0] WrData;
  logic [DATA_WIDTH-1:0] RdData;
  logic                  RdData_Valid;
  // ALU side
  logic                  ALU_EN;
  logic [3:0]            ALU_FUN;
  logic                  CLK_EN;
  logic [OUT_WIDTH-1:0]  ALU_OUT;
  logic                  OUT_VALID;
  // TX side
  logic [DATA_WIDTH-1:0] TX_P_DATA;
  logic                  TX_D_VLD;
  logic                  FIFO_FULL;
  // status
  logic                  CMD_ERR;

  // The sequencer drives the control strobes and consumes the returned data
  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_VALID, FIFO_FULL,
    output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD, CMD_ERR
  );

  // The surrounding system sees the mirror image
  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_VALID, FIFO_FULL,
    input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD, CMD_ERR
  );
endinterface

// File: rtl/sys_cmd_ctrl.sv
// Frame command sequencer: decodes RX bytes into register file / ALU operations and returns results as TX bytes.
// Latency: every output is registered, one cycle after the triggering strobe.
// Backpressure: TX bytes are held in TX_LO/TX_HI while FIFO_FULL is high; RX bytes arriving while busy are dropped with CMD_ERR.
module sys_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int ADDR       = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  sys_cmd_ctrl_if.master  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'('hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'('hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'('hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'('hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
    OP_A, OP_B, ALU_FUN_S, ALU_WAIT, TX_LO, TX_HI
  } state_t;

  state_t                r_state;
  logic                  r_wr_en;
  logic                  r_rd_en;
  logic [ADDR-1:0]       r_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_alu_en;
  logic [3:0]            r_alu_fun;
  logic                  r_clk_en;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_vld;
  logic                  r_cmd_err;
  logic [OUT_WIDTH-1:0]  r_result;
  logic                  r_two_byte;
  logic [TW-1:0]         r_timer;

  logic [DATA_WIDTH-1:0] w_rx_byte;
  logic                  w_rx_vld;
  logic                  w_timer_done;

  assign w_rx_byte    = bus.RX_P_DATA;
  assign w_rx_vld     = bus.RX_D_VLD;
  assign w_timer_done = (r_timer == TW'(TIMEOUT - 1));

  // Command FSM; strobes default low each cycle so each event yields a single-cycle pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_addr     <= '0;
      r_wr_data  <= '0;
      r_alu_en   <= 1'b0;
      r_alu_fun  <= '0;
      r_clk_en   <= 1'b0;
      r_tx_data  <= '0;
      r_tx_vld   <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_result   <= '0;
      r_two_byte <= 1'b0;
      r_timer    <= '0;
    end else begin
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_alu_en  <= 1'b0;
      r_tx_vld  <= 1'b0;
      r_cmd_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rx_vld) begin
            case (w_rx_byte)
              CMD_WR:     r_state <= WR_ADDR;
              CMD_RD:     r_state <= RD_ADDR;
              CMD_ALU_OP: r_state <= OP_A;
              CMD_ALU_NO: r_state <= ALU_FUN_S;
              default:    r_cmd_err <= 1'b1;
            endcase
          end
        end
        WR_ADDR: begin
          if (w_rx_vld) begin
            r_addr  <= w_rx_byte[ADDR-1:0];
            r_state <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (w_rx_vld) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= w_rx_byte;
            r_state   <= IDLE;
          end
        end
        RD_ADDR: begin
          if (w_rx_vld) begin
            r_rd_en <= 1'b1;
            r_addr  <= w_rx_byte[ADDR-1:0];
            r_timer <= '0;
            r_state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (w_rx_vld) r_cmd_err <= 1'b1;
          if (bus.RdData_Valid) begin
            r_result   <= {{(OUT_WIDTH-DATA_WIDTH){1'b0}}, bus.RdData};
            r_two_byte <= 1'b0;
            r_state    <= TX_LO;
          end else if (w_timer_done) begin
            r_cmd_err <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        OP_A: begin
          // operand A lands in register 0
          if (w_rx_vld) begin
            r_wr_en   <= 1'b1;
            r_addr    <= '0;
            r_wr_data <= w_rx_byte;
            r_state   <= OP_B;
          end
        end
        OP_B: begin
          // operand B lands in register 1
          if (w_rx_vld) begin
            r_wr_en   <= 1'b1;
            r_addr    <= ADDR'(1);
            r_wr_data <= w_rx_byte;
            r_state   <= ALU_FUN_S;
          end
        end
        ALU_FUN_S: begin
          if (w_rx_vld) begin
            r_alu_en  <= 1'b1;
            r_alu_fun <= w_rx_byte[3:0];
            r_clk_en  <= 1'b1;
            r_timer   <= '0;
            r_state   <= ALU_WAIT;
          end
        end
        ALU_WAIT: begin
          if (w_rx_vld) r_cmd_err <= 1'b1;
          if (bus.OUT_VALID) begin
            r_result   <= bus.ALU_OUT;
            r_two_byte <= 1'b1;
            r_clk_en   <= 1'b0;
            r_state    <= TX_LO;
          end else if (w_timer_done) begin
            r_cmd_err <= 1'b1;
            r_clk_en  <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        TX_LO: begin
          if (w_rx_vld) r_cmd_err <= 1'b1;
          if (!bus.FIFO_FULL) begin
            r_tx_vld  <= 1'b1;
            r_tx_data <= r_result[DATA_WIDTH-1:0];
            r_state   <= r_two_byte ? TX_HI : IDLE;
          end
        end
        TX_HI: begin
          if (w_rx_vld) r_cmd_err <= 1'b1;
          if (!bus.FIFO_FULL) begin
            r_tx_vld  <= 1'b1;
            r_tx_data <= r_result[DATA_WIDTH +: DATA_WIDTH];
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.WrEn      = r_wr_en;
  assign bus.RdEn      = r_rd_en;
  assign bus.Address   = r_addr;
  assign bus.WrData    = r_wr_data;
  assign bus.ALU_EN    = r_alu_en;
  assign bus.ALU_FUN   = r_alu_fun;
  assign bus.CLK_EN    = r_clk_en;
  assign bus.TX_P_DATA = r_tx_data;
  assign bus.TX_D_VLD  = r_tx_vld;
  assign bus.CMD_ERR   = r_cmd_err;

endmodule
